// File: rtl/mux_arbiter.sv
// Two-requester arbiter that drives a shared 2-way mux and registers the winning word onto one valid/ready channel.
// Optional feature: define MUX_ARB_RR_EN for round-robin contention; otherwise A has fixed priority.
`ifndef WORD
`define WORD 16
`endif

module mux_arbiter #(
  parameter int unsigned WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ack,
  output logic             control,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             control_q;
  logic             a_elig;
  logic             b_elig;
  logic             any_elig;
  logic             win;
  logic             cap;
  logic [WIDTH-1:0] mux_out;
`ifdef MUX_ARB_RR_EN
  logic             last;
`endif

  // A requester acked this cycle still shows its old word, so it is masked.
  always_comb begin
    a_elig   = a_req & ~a_ack;
    b_elig   = b_req & ~b_ack;
    any_elig = a_elig | b_elig;
`ifdef MUX_ARB_RR_EN
    win      = (a_elig && b_elig) ? ~last : b_elig;
`else
    win      = ~a_elig & b_elig;
`endif
    control  = reset ? 1'b0 : (any_elig ? win : control_q);
    mux_out  = control ? b_data : a_data;
    cap      = ((state == IDLE) || out_ready) && any_elig;
  end

  assign out_valid = (state == FULL);

  // Output register, one-cycle acks and select hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_src   <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      control_q <= 1'b0;
`ifdef MUX_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      a_ack     <= cap & ~win;
      b_ack     <= cap & win;
      control_q <= control;
      if (cap) begin
        state    <= FULL;
        out_data <= mux_out;
        out_src  <= win;
`ifdef MUX_ARB_RR_EN
        last     <= win;
`endif
      end else if (out_ready) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed vector bench for mux_arbiter; expectations follow the MUX_ARB_RR_EN build option.
`timescale 1ns/1ps

module tb_mux_arbiter;

  localparam int unsigned W = 16;
`ifdef MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         a_req, b_req, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ack, b_ack, control, out_valid, out_src;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
    .control(control), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           r;
    bit           ar;
    logic [W-1:0] ad;
    bit           br;
    logic [W-1:0] bd;
    bit           rdy;
    bit           ctl;
    bit           v;
    logic [W-1:0] d;
    bit           s;
    bit           aa;
    bit           ba;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(bit r, bit ar, logic [W-1:0] ad, bit br, logic [W-1:0] bd, bit rdy,
                              bit ctl, bit v, logic [W-1:0] d, bit s, bit aa, bit ba);
    vec_t t;
    t.r = r; t.ar = ar; t.ad = ad; t.br = br; t.bd = bd; t.rdy = rdy;
    t.ctl = ctl; t.v = v; t.d = d; t.s = s; t.aa = aa; t.ba = ba;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Acks must never be asserted together.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (a_ack === 1'b1 && b_ack === 1'b1) begin
        errors++;
        $display("FAIL ack_overlap: got a_ack=1 b_ack=1 expected at most one");
      end
    end
  end

  initial begin
    logic [W-1:0] d_a, d_b;
    bit found;
    d_a = 16'd654;
    d_b = 16'd15;
    //                r  ar ad       br bd        rdy ctl  v  d                    s    aa   ba
    vecs[0]  = mk(1, 1, d_a,     0, 16'd0,     1,  0,   0, 16'd0,               0,   0,   0);
    vecs[1]  = mk(1, 1, d_a,     0, 16'd0,     1,  0,   0, 16'd0,               0,   0,   0);
    vecs[2]  = mk(0, 1, d_a,     0, 16'd0,     1,  0,   1, d_a,                 0,   1,   0);
    vecs[3]  = mk(0, 0, d_a,     0, 16'd0,     1,  0,   0, d_a,                 0,   0,   0);
    vecs[4]  = mk(0, 1, d_a,     1, d_b,       1,  RR,  1, RR ? d_b : d_a,      RR,  !RR, RR);
    vecs[5]  = mk(0, 1, d_a,     1, d_b,       1,  !RR, 1, RR ? d_a : d_b,      !RR, RR,  !RR);
    vecs[6]  = mk(0, 1, d_a,     1, d_b,       1,  RR,  1, RR ? d_b : d_a,      RR,  !RR, RR);
    vecs[7]  = mk(0, 1, d_a,     1, d_b,       1,  !RR, 1, RR ? d_a : d_b,      !RR, RR,  !RR);
    vecs[8]  = mk(0, 0, d_a,     0, d_b,       1,  !RR, 0, RR ? d_a : d_b,      !RR, 0,   0);
    vecs[9]  = mk(0, 0, d_a,     1, 16'd43778, 1,  1,   1, 16'd43778,           1,   0,   1);
    vecs[10] = mk(0, 1, 16'd7110, 0, 16'd0,    0,  0,   1, 16'd43778,           1,   0,   0);
    vecs[11] = mk(0, 1, 16'd7110, 0, 16'd0,    0,  0,   1, 16'd43778,           1,   0,   0);
    vecs[12] = mk(0, 1, 16'd7110, 0, 16'd0,    0,  0,   1, 16'd43778,           1,   0,   0);
    vecs[13] = mk(0, 1, 16'd7110, 0, 16'd0,    1,  0,   1, 16'd7110,            0,   1,   0);
    vecs[14] = mk(0, 0, 16'd7110, 0, 16'd0,    1,  0,   0, 16'd7110,            0,   0,   0);
    vecs[15] = mk(0, 0, 16'd0,   1, d_b,       0,  1,   1, d_b,                 1,   0,   1);
    vecs[16] = mk(0, 0, 16'd0,   0, d_b,       0,  1,   1, d_b,                 1,   0,   0);
    vecs[17] = mk(1, 0, 16'd0,   0, d_b,       0,  0,   0, 16'd0,               0,   0,   0);
    vecs[18] = mk(0, 1, 16'd7110, 1, d_b,      1,  0,   1, 16'd7110,            0,   1,   0);
    vecs[19] = mk(0, 0, 16'd7110, 0, d_b,      0,  0,   1, 16'd7110,            0,   0,   0);
    vecs[20] = mk(0, 0, 16'd7110, 0, d_b,      1,  0,   0, 16'd7110,            0,   0,   0);

    reset = 1'b1; a_req = 1'b0; b_req = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = vecs[i].r; a_req = vecs[i].ar; a_data = vecs[i].ad;
      b_req = vecs[i].br; b_data = vecs[i].bd; out_ready = vecs[i].rdy;
      #1;
      chk("control", i, W'(control), W'(vecs[i].ctl));
      @(posedge clk);
      #1;
      chk("out_valid", i, W'(out_valid), W'(vecs[i].v));
      chk("out_data",  i, out_data,      vecs[i].d);
      chk("out_src",   i, W'(out_src),   W'(vecs[i].s));
      chk("a_ack",     i, W'(a_ack),     W'(vecs[i].aa));
      chk("b_ack",     i, W'(b_ack),     W'(vecs[i].ba));
    end

    // Handshake: hold b_req until the ack is seen, then drop it on the ack cycle.
    @(negedge clk);
    b_req = 1'b1; b_data = 16'd999; a_req = 1'b0; out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(posedge clk);
      #1;
      if (b_ack === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hs_ack_timeout: got no b_ack expected b_ack within 4 cycles");
    end
    chk("hs_data", 100, out_data, 16'd999);
    chk("hs_src",  100, W'(out_src), W'(1'b1));
    @(negedge clk);
    b_req = 1'b0;
    @(posedge clk);
    #1;
    chk("hs_ack_once", 101, W'(b_ack),     W'(1'b0));
    chk("hs_drain",    101, W'(out_valid), W'(1'b0));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
